// File: rtl/rr_grant_controller.sv
// rtl/rr_grant_controller.sv - round-robin grant controller with per-transaction hold and timeout
module rr_grant_controller #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [N-1:0]                          i_req,
  input  logic                                  i_done,
  output logic [N-1:0]                          o_gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  o_gnt_idx,
  output logic                                  o_gnt_valid,
  output logic                                  o_timeout
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           valid_q, valid_d;
  logic           timeout_q, timeout_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [IW-1:0]  ptr_q, ptr_d;

  logic           rel_done, rel_drop, rel_to, release_now;
  logic [IW-1:0]  search_ptr;
  logic           win_found;
  logic [IW-1:0]  win_idx;

  // Release conditions for the current holder; only meaningful in BUSY.
  always_comb begin
    rel_done    = i_done;
    rel_drop    = ~i_req[idx_q];
    rel_to      = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD));
    release_now = (state_q == BUSY) && (rel_done || rel_drop || rel_to);
    // On a release the search starts just past the releasing index, so it loses ties.
    search_ptr  = release_now ? IW'((int'(idx_q) + 1) % N) : ptr_q;
  end

  // First requesting index at or after search_ptr, wrapping; scanning downwards lets the lowest offset win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(search_ptr) + k) % N]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(search_ptr) + k) % N);
      end
    end
  end

  // Next-state: grant from IDLE, hold or hand over back-to-back in BUSY.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          gnt_d   = N'(1) << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          hold_d  = HW'(1);
        end
      end
      BUSY: begin
        if (release_now) begin
          ptr_d     = search_ptr;
          timeout_d = rel_to && !rel_done && !rel_drop;
          if (win_found) begin
            gnt_d  = N'(1) << win_idx;
            idx_d  = win_idx;
            hold_d = HW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (hold_q != {HW{1'b1}}) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      ptr_q     <= ptr_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_gnt_idx   = idx_q;
  assign o_gnt_valid = valid_q;
  assign o_timeout   = timeout_q;

  a_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(gnt_q));
  a_busy_valid : assert property (@(posedge i_clk) disable iff (i_rst) (state_q == BUSY) |-> valid_q);

endmodule
